// File: rtl/cp0_exc_sequencer_pkg.sv
// Shared CP0 register addresses, the Status.EXL bit position and the sequencer state encoding.
package cp0_exc_sequencer_pkg;

    localparam logic [7:0] CP0_BADV   = 8'h40;
    localparam logic [7:0] CP0_STATUS = 8'h60;
    localparam logic [7:0] CP0_CAUSE  = 8'h68;
    localparam logic [7:0] CP0_EPC    = 8'h70;

    localparam int EXL_BIT = 1;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_E_RD_STATUS  = 4'd1,
        ST_E_WR_EPC     = 4'd2,
        ST_E_WR_BADV    = 4'd3,
        ST_E_WR_CAUSE   = 4'd4,
        ST_E_WR_STATUS  = 4'd5,
        ST_E_REDIRECT   = 4'd6,
        ST_R_RD_EPC     = 4'd7,
        ST_R_RD_STATUS  = 4'd8,
        ST_R_WR_STATUS  = 4'd9,
        ST_R_REDIRECT   = 4'd10
    } state_e;

    // Cause image: BD in bit 31, ExcCode in bits 6:2; CP0 itself keeps the IP bits.
    function automatic logic [31:0] cause_word(input logic bd, input logic [4:0] code);
        return {bd, 15'b0, 8'b0, 1'b0, code, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_exc_sequencer.sv
// CP0 write/read port owner: passes MTC0 writes through when idle and runs the fixed
// exception/interrupt/ERET read-modify-write programs, ending in flush plus redirect.
module cp0_exc_sequencer
    import cp0_exc_sequencer_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 8,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [4:0]        exc_code,
    input  logic              int_req,
    input  logic              eret_valid,
    input  logic [DATA_W-1:0] victim_pc,
    input  logic              victim_bd,
    input  logic              badv_valid,
    input  logic [DATA_W-1:0] badv_addr,
    input  logic              mtc0_valid,
    input  logic [ADDR_W-1:0] mtc0_addr,
    input  logic [DATA_W-1:0] mtc0_data,
    output logic              mtc0_ready,
    output logic [ADDR_W-1:0] cp0_raddr,
    input  logic [DATA_W-1:0] cp0_rdata,
    output logic              cp0_we,
    output logic [ADDR_W-1:0] cp0_waddr,
    output logic [DATA_W-1:0] cp0_wdata,
    output logic              busy,
    output logic              flush,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [3:0]        dbg_state
);

    localparam logic [DATA_W-1:0] EXL_MASK = DATA_W'(1) << EXL_BIT;

    state_e            state_q;
    logic [4:0]        code_q;
    logic [DATA_W-1:0] pc_q;
    logic              bd_q;
    logic              badv_valid_q;
    logic [DATA_W-1:0] badv_q;
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] epc_q;
    logic              idle_free;

    // MTC0 handshake: a write completes in the cycle mtc0_valid && mtc0_ready; the requester
    // holds address/data stable until then. Ready drops while busy or while any higher-priority
    // commit event is present in the same cycle.
    assign idle_free = (state_q == ST_IDLE) && !exc_valid && !int_req && !eret_valid;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            pc_q         <= '0;
            bd_q         <= 1'b0;
            badv_valid_q <= 1'b0;
            badv_q       <= '0;
            status_q     <= '0;
            epc_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (exc_valid) begin
                        state_q      <= ST_E_RD_STATUS;
                        code_q       <= exc_code;
                        pc_q         <= victim_pc;
                        bd_q         <= victim_bd;
                        badv_valid_q <= badv_valid;
                        badv_q       <= badv_addr;
                    end else if (int_req) begin
                        state_q      <= ST_E_RD_STATUS;
                        code_q       <= 5'd0;
                        pc_q         <= victim_pc;
                        bd_q         <= victim_bd;
                        badv_valid_q <= 1'b0;
                    end else if (eret_valid) begin
                        state_q <= ST_R_RD_EPC;
                    end
                end
                ST_E_RD_STATUS: state_q <= ST_E_WR_EPC;
                ST_E_WR_EPC: begin
                    status_q <= cp0_rdata;
                    state_q  <= badv_valid_q ? ST_E_WR_BADV : ST_E_WR_CAUSE;
                end
                ST_E_WR_BADV:   state_q <= ST_E_WR_CAUSE;
                ST_E_WR_CAUSE:  state_q <= ST_E_WR_STATUS;
                ST_E_WR_STATUS: state_q <= ST_E_REDIRECT;
                ST_E_REDIRECT:  state_q <= ST_IDLE;
                ST_R_RD_EPC:    state_q <= ST_R_RD_STATUS;
                ST_R_RD_STATUS: begin
                    epc_q   <= cp0_rdata;
                    state_q <= ST_R_WR_STATUS;
                end
                ST_R_WR_STATUS: state_q <= ST_R_REDIRECT;
                ST_R_REDIRECT:  state_q <= ST_IDLE;
                default:        state_q <= ST_IDLE;
            endcase
        end
    end

    // Port drive decoded from state; E2 and R3 consume cp0_rdata in the cycle it arrives.
    always_comb begin
        mtc0_ready     = 1'b0;
        cp0_raddr      = '0;
        cp0_we         = 1'b0;
        cp0_waddr      = '0;
        cp0_wdata      = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            ST_IDLE: begin
                mtc0_ready = idle_free;
                if (mtc0_valid && idle_free) begin
                    cp0_we    = 1'b1;
                    cp0_waddr = mtc0_addr;
                    cp0_wdata = mtc0_data;
                end
            end
            ST_E_RD_STATUS: cp0_raddr = CP0_STATUS;
            ST_E_WR_EPC: begin
                cp0_we    = !cp0_rdata[EXL_BIT];
                cp0_waddr = CP0_EPC;
                cp0_wdata = bd_q ? (pc_q - DATA_W'(4)) : pc_q;
            end
            ST_E_WR_BADV: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_BADV;
                cp0_wdata = badv_q;
            end
            ST_E_WR_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_CAUSE;
                cp0_wdata = cause_word(bd_q, code_q);
            end
            ST_E_WR_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_STATUS;
                cp0_wdata = status_q | EXL_MASK;
            end
            ST_E_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
            end
            ST_R_RD_EPC:    cp0_raddr = CP0_EPC;
            ST_R_RD_STATUS: cp0_raddr = CP0_STATUS;
            ST_R_WR_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = CP0_STATUS;
                cp0_wdata = cp0_rdata & ~EXL_MASK;
            end
            ST_R_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = epc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Randomized bench for cp0_exc_sequencer: a CP0 register-file responder plus an
// event-level model that schedules each expected CP0 access and redirect by cycle.
module tb_cp0_exc_sequencer;
    import cp0_exc_sequencer_pkg::*;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, int_req, eret_valid, victim_bd, badv_valid, mtc0_valid;
    logic [4:0]  exc_code;
    logic [31:0] victim_pc, badv_addr, mtc0_data;
    logic [7:0]  mtc0_addr;
    logic        mtc0_ready, cp0_we, busy, flush, redirect_valid;
    logic [7:0]  cp0_raddr, cp0_waddr;
    logic [31:0] cp0_rdata = '0;
    logic [31:0] cp0_wdata, redirect_pc;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    cp0_exc_sequencer #(.DATA_W(32), .ADDR_W(8), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .int_req(int_req), .eret_valid(eret_valid),
        .victim_pc(victim_pc), .victim_bd(victim_bd), .badv_valid(badv_valid), .badv_addr(badv_addr),
        .mtc0_valid(mtc0_valid), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mtc0_ready(mtc0_ready),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .busy(busy), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .dbg_state(dbg_state)
    );

    // CP0 register file responder: registered read, write on the clock edge.
    logic [31:0] cp0_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (cp0_we) cp0_mem[cp0_waddr] <= cp0_wdata;
        cp0_rdata <= cp0_mem[cp0_raddr];
    end

    // Reference model state
    logic [31:0] shadow [256] = '{default: '0};
    logic [71:0] exp_q[$];   // {cycle, waddr, wdata}
    logic [39:0] rd_q[$];    // {cycle, raddr}
    int          cyc = 0;
    int          acc_cyc = -1;
    int          redir_cyc = -1;
    logic [31:0] redir_pc = '0;
    bit          mtc0_pend = 0;
    bit          mtc0_acc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic zero_inputs();
        exc_valid = 0; exc_code = '0; int_req = 0; eret_valid = 0;
        victim_pc = '0; victim_bd = 0; badv_valid = 0; badv_addr = '0;
        mtc0_valid = 0; mtc0_addr = '0; mtc0_data = '0;
    endtask

    task automatic sched_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                             input logic bv, input logic [31:0] ba);
        logic [31:0] st;
        int t;
        st = shadow[CP0_STATUS];
        acc_cyc = cyc;
        rd_q.push_back({32'(cyc + 1), CP0_STATUS});
        t = cyc + 2;
        if (st[1] == 1'b0) exp_q.push_back({32'(t), CP0_EPC, bd ? pc - 32'd4 : pc});
        t++;
        if (bv) begin
            exp_q.push_back({32'(t), CP0_BADV, ba});
            t++;
        end
        exp_q.push_back({32'(t), CP0_CAUSE, (32'(bd) << 31) | (32'(code) << 2)});
        exp_q.push_back({32'(t + 1), CP0_STATUS, st | 32'h2});
        redir_cyc = t + 2;
        redir_pc  = VEC;
    endtask

    task automatic sched_eret();
        acc_cyc = cyc;
        rd_q.push_back({32'(cyc + 1), CP0_EPC});
        rd_q.push_back({32'(cyc + 2), CP0_STATUS});
        exp_q.push_back({32'(cyc + 3), CP0_STATUS, shadow[CP0_STATUS] & ~32'h2});
        redir_cyc = cyc + 4;
        redir_pc  = shadow[CP0_EPC];
    endtask

    // Called at a falling edge with inputs already driven; checks this cycle, then advances.
    task automatic step();
        bit          busy_e, ready_e, we_e, rv_e;
        logic [7:0]  ra_e;
        logic [71:0] e;
        #4;
        busy_e  = (acc_cyc >= 0) && (cyc > acc_cyc) && (cyc <= redir_cyc);
        ready_e = !busy_e && !exc_valid && !int_req && !eret_valid;
        mtc0_acc = 0;
        if (!busy_e) begin
            if (exc_valid)       sched_exc(exc_code, victim_pc, victim_bd, badv_valid, badv_addr);
            else if (int_req)    sched_exc(5'd0, victim_pc, victim_bd, 1'b0, 32'd0);
            else if (eret_valid) sched_eret();
            else if (mtc0_valid) begin
                exp_q.push_back({32'(cyc), mtc0_addr, mtc0_data});
                mtc0_acc = 1;
            end
        end
        check("mtc0_ready", mtc0_ready, ready_e);
        check("busy", busy, busy_e);
        we_e = (exp_q.size() > 0) && (exp_q[0][71:40] == 32'(cyc));
        check("cp0_we", cp0_we, we_e);
        if (we_e) begin
            e = exp_q.pop_front();
            if (cp0_we) begin
                check("cp0_waddr", cp0_waddr, e[39:32]);
                check("cp0_wdata", cp0_wdata, e[31:0]);
            end
            shadow[e[39:32]] = e[31:0];
        end
        ra_e = 8'h00;
        if ((rd_q.size() > 0) && (rd_q[0][39:8] == 32'(cyc))) begin
            ra_e = rd_q[0][7:0];
            void'(rd_q.pop_front());
        end
        check("cp0_raddr", cp0_raddr, ra_e);
        rv_e = (cyc == redir_cyc);
        check("redirect_valid", redirect_valid, rv_e);
        check("flush", flush, rv_e);
        if (rv_e) check("redirect_pc", redirect_pc, redir_pc);
        mtc0_pend = mtc0_valid && !mtc0_acc;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic mtc0_write(input logic [7:0] a, input logic [31:0] d);
        mtc0_valid = 1; mtc0_addr = a; mtc0_data = d;
        step();
        mtc0_valid = 0;
    endtask

    task automatic drive_random();
        if (!mtc0_pend) begin
            mtc0_valid = ($urandom_range(0, 3) == 0);
            mtc0_data  = $urandom;
            case ($urandom_range(0, 4))
                0: mtc0_addr = CP0_STATUS;
                1: mtc0_addr = CP0_EPC;
                2: mtc0_addr = CP0_CAUSE;
                3: mtc0_addr = CP0_BADV;
                default: mtc0_addr = 8'($urandom);
            endcase
        end
        exc_valid  = ($urandom_range(0, 9) == 0);
        exc_code   = 5'($urandom);
        int_req    = ($urandom_range(0, 9) == 0);
        eret_valid = ($urandom_range(0, 9) == 0);
        victim_pc  = $urandom;
        victim_bd  = 1'($urandom);
        badv_valid = 1'($urandom);
        badv_addr  = $urandom;
    endtask

    initial begin
        rst = 0;
        zero_inputs();
        @(negedge clk);
        #2;
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_busy", busy, 0);
        check("rst_we", cp0_we, 0);
        check("rst_waddr", cp0_waddr, 0);
        check("rst_wdata", cp0_wdata, 0);
        check("rst_raddr", cp0_raddr, 0);
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_mtc0_ready", mtc0_ready, 1);
        rst = 1;
        @(negedge clk);

        // Exception with bad address, EXL clear
        mtc0_write(CP0_STATUS, 32'h0000FF00);
        exc_valid = 1; exc_code = 5'h04; victim_pc = 32'h80000010; victim_bd = 0;
        badv_valid = 1; badv_addr = 32'h1234;
        step();
        zero_inputs();
        repeat (7) step();

        // EXL now set: EPC write suppressed, no bad address
        exc_valid = 1; exc_code = 5'h0A; victim_pc = 32'h80000020; victim_bd = 1;
        step();
        zero_inputs();
        repeat (6) step();

        // ERET
        mtc0_write(CP0_EPC, 32'h80001000);
        mtc0_write(CP0_STATUS, 32'h0000FF03);
        eret_valid = 1;
        step();
        zero_inputs();
        repeat (5) step();

        // Exception and MTC0 together: MTC0 waits for the sequence to finish
        exc_valid = 1; exc_code = 5'h08; victim_pc = 32'h80000100;
        mtc0_valid = 1; mtc0_addr = CP0_CAUSE; mtc0_data = 32'hA5A5_0000;
        step();
        exc_valid = 0;
        for (int i = 0; i < 20 && !mtc0_acc; i++) step();
        zero_inputs();
        step();

        // Interrupt beats ERET
        mtc0_write(CP0_STATUS, 32'h0000FF00);
        int_req = 1; eret_valid = 1; victim_pc = 32'h80000200; exc_code = 5'h1F;
        badv_valid = 1; badv_addr = 32'hDEAD;
        step();
        zero_inputs();
        repeat (6) step();

        // Reset in WR_CAUSE aborts without the Status write
        mtc0_write(CP0_STATUS, 32'h0000FF00);
        exc_valid = 1; exc_code = 5'h05; victim_pc = 32'h80000300;
        badv_valid = 1; badv_addr = 32'h5678;
        step();
        zero_inputs();
        repeat (3) step();
        rst = 0;
        #2;
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_busy", busy, 0);
        check("midrst_we", cp0_we, 0);
        check("midrst_wdata", cp0_wdata, 0);
        check("midrst_flush", flush, 0);
        check("midrst_redirect", redirect_valid, 0);
        exp_q.delete();
        rd_q.delete();
        acc_cyc = -1;
        redir_cyc = -1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1;
        repeat (6) step();
        check("midrst_status_kept", cp0_mem[CP0_STATUS], 32'h0000FF00);

        // Random traffic
        mtc0_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end
        zero_inputs();
        repeat (8) step();
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
